// File: rtl/rr_sched_pkg.sv
// Shared constants and types for the round-robin read scheduler.
// Holds the switch-wide widths (input count, pointer MSB, packet MSB),
// the flag levels, and a small pointer helper used by rr_sched.
package rr_sched_pkg;

  // Number of input FIFOs served; fixed for the whole switch.
  localparam int NIN  = 4;
  // MSB index of the round-robin pointer / grant index.
  localparam int NINB = 1;
  // MSB index of a packet; packets are PKTW+1 bits wide.
  localparam int PKTW = 9;
  // Width of the optional forwarded-packet counter.
  localparam int CNTW = 16;

  // Flag levels used for empty/re/vo style strobes.
  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  typedef logic [NINB:0] idx_t;
  typedef logic [PKTW:0] pkt_t;

  // Pointer advance with natural wrap at NIN (NIN is a power of two).
  function automatic idx_t next_idx(input idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter.
// Scans the request vector starting at the priority pointer and wrapping
// modulo NIN; returns a one-hot grant (zero when nothing requests) and the
// index of the granted input.
module rr_arb
  import rr_sched_pkg::*;
(
  input  logic [NIN-1:0]  req,
  input  logic [NINB:0]   rr,
  output logic [NIN-1:0]  gnt,
  output logic [NINB:0]   gidx
);

  // Pick the first requester at or after rr, wrapping around.
  always_comb begin : scan
    idx_t cand;
    logic found;
    // NOTE: every output gets a default before the loop, so no path leaves
    // a variable unassigned and no latch is inferred.
    gnt   = '0;
    gidx  = rr;
    found = NEGATE;
    cand  = rr;
    for (int k = 0; k < NIN; k++) begin
      cand = rr + idx_t'(k);
      if (!found && req[cand] == ASSERT) begin
        found     = ASSERT;
        gnt[cand] = ASSERT;
        gidx      = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sched.sv
// Round-robin read scheduler for four input FIFOs.
// Pops at most one packet per cycle from a non-empty FIFO in round-robin
// order and presents it on a registered valid/ready output. It owns the
// FIFO pop strobes and never pops an empty FIFO.
// Optional feature: define SW_PKTCNT_EN to add the 16-bit forwarded-packet
// counter and its pktcnt port.
module rr_sched
  import rr_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NIN-1:0]          empty,
  input  logic [NIN*(PKTW+1)-1:0] pkti,
  output logic [NIN-1:0]          re,
  output logic [PKTW:0]           pkto,
  output logic                    vo,
  input  logic                    ri
`ifdef SW_PKTCNT_EN
  ,
  output logic [CNTW-1:0]         pktcnt
`endif
);

  idx_t           rr;
  idx_t           gidx;
  logic [NIN-1:0] req;
  logic [NIN-1:0] gnt;
  logic           free;
  logic           gvalid;
  logic           xfer;
  pkt_t           heads [NIN];

  // Split the concatenated FIFO head bus into one packet per input.
  for (genvar g = 0; g < NIN; g++) begin : g_head
    assign heads[g] = pkti[g*(PKTW+1) +: (PKTW+1)];
  end

  // The output slot can take a new packet when empty or draining this cycle.
  assign free = !vo || (ri == ASSERT);
  assign xfer = vo && (ri == ASSERT);

  // Only non-empty FIFOs request, only when the slot is free, never in reset.
  assign req = (rst == ASSERT) ? '0 : (~empty & {NIN{free}});

  rr_arb u_arb (
    .req  (req),
    .rr   (rr),
    .gnt  (gnt),
    .gidx (gidx)
  );

  // The grant doubles as the FIFO pop strobe in the same cycle.
  assign re     = gnt;
  assign gvalid = |gnt;

  // Output register and priority pointer: load on grant, clear on drain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst == ASSERT) begin
      vo   <= NEGATE;
      pkto <= '0;
      rr   <= '0;
    end else if (gvalid) begin
      pkto <= heads[gidx];
      vo   <= ASSERT;
      rr   <= next_idx(gidx);
    end else if (xfer) begin
      vo   <= NEGATE;
    end
  end

`ifdef SW_PKTCNT_EN
  // Count every accepted output transfer; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst == ASSERT) begin
      pktcnt <= '0;
    end else if (xfer) begin
      pktcnt <= pktcnt + CNTW'(1);
    end
  end
`endif

  // Pop strobes are one-hot or zero and never target an empty FIFO.
  a_re_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(re));
  a_re_nonempty : assert property (@(posedge clk) disable iff (rst) (re & empty) == '0);
  a_re_rst : assert property (@(posedge clk) rst |-> re == '0);

endmodule

// File: tb/tb_rr_sched.sv
// Directed bench for rr_sched. FIFO contents live in bench queues; a
// behavioural model derives the expected pop strobe, output packet/valid and
// (optionally) the transfer count every cycle, and literal expectations pin
// the reset, single-source, round-robin, backpressure and wrap scenarios.
module tb_rr_sched;
  import rr_sched_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ri;
  logic [NIN-1:0]          empty;
  logic [NIN-1:0]          re;
  logic [NIN*(PKTW+1)-1:0] pkti;
  logic [PKTW:0]           pkto;
  logic                    vo;
`ifdef SW_PKTCNT_EN
  logic [15:0]             pktcnt;
`endif

  always #5 clk = ~clk;

  rr_sched dut (
    .clk    (clk),
    .rst    (rst),
    .empty  (empty),
    .pkti   (pkti),
    .re     (re),
    .pkto   (pkto),
    .vo     (vo),
    .ri     (ri)
`ifdef SW_PKTCNT_EN
    ,
    .pktcnt (pktcnt)
`endif
  );

  // FIFO contents and model state.
  logic [PKTW:0] fq [NIN][$];
  logic          m_vo    = 1'b0;
  logic          m_known = 1'b0;
  logic [PKTW:0] m_pkto  = '0;
  int            m_rr    = 0;
  logic [15:0]   m_cnt   = '0;
  int            xfers   = 0;

  // Per-cycle logs of what the DUT showed, for the literal checks.
  logic [NIN-1:0] re_log   [$];
  logic           vo_log   [$];
  logic [PKTW:0]  pkto_log [$];

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic any_nonempty();
    logic r = 1'b0;
    for (int i = 0; i < NIN; i++) if (fq[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NIN; i++) begin
      empty[i] = (fq[i].size() == 0);
      pkti[i*(PKTW+1) +: (PKTW+1)] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  // One clock cycle: drive FIFO view, compare at the falling edge, advance
  // the model at the rising edge.
  task automatic step();
    logic           free;
    logic [NIN-1:0] exp_re;
    int             g;
    int             idx;
    drive_inputs();
    @(negedge clk);
    free = !m_vo || ri;
    g = -1;
    if (!rst && free) begin
      for (int k = 0; k < NIN; k++) begin
        idx = (m_rr + k) % NIN;
        if (g < 0 && fq[idx].size() != 0) g = idx;
      end
    end
    exp_re = (g >= 0) ? NIN'(1 << g) : '0;
    check("re", 32'(re), 32'(exp_re));
    if (m_known) begin
      check("vo", 32'(vo), 32'(m_vo));
      if (m_vo) check("pkto", 32'(pkto), 32'(m_pkto));
`ifdef SW_PKTCNT_EN
      check("pktcnt", 32'(pktcnt), 32'(m_cnt));
`endif
    end
    re_log.push_back(re);
    vo_log.push_back(vo);
    pkto_log.push_back(pkto);
    @(posedge clk);
    if (rst) begin
      m_vo = 1'b0; m_pkto = '0; m_rr = 0; m_cnt = '0; xfers = 0;
      m_known = 1'b1;
    end else begin
      if (m_vo && ri) begin
        m_cnt = m_cnt + 16'd1;
        xfers++;
      end
      if (g >= 0) begin
        m_pkto = fq[g].pop_front();
        m_vo   = 1'b1;
        m_rr   = (g + 1) % NIN;
      end else if (ri) begin
        m_vo = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_vo || any_nonempty()) && guard < 64) begin
      step();
      guard++;
    end
    check("drain_bound", 32'(guard < 64), 32'd1);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    ri  = 1'b1;
    for (int i = 0; i < NIN; i++) drive_inputs();

    // Reset held two cycles with every FIFO non-empty.
    for (int i = 0; i < NIN; i++) begin
      fq[i].push_back(10'(12'h0F0 + i));
      fq[i].push_back(10'(12'h0E0 + i));
    end
    step();
    step();
    check("rst_re0", 32'(re_log[0]), 32'h0);
    check("rst_re1", 32'(re_log[1]), 32'h0);
    rst = 1'b0;
    base = re_log.size();
    step();
    check("rel_vo", 32'(vo_log[base]), 32'd0);
    check("rel_pkto", 32'(pkto_log[base]), 32'h000);
    check("rel_rr0", 32'(re_log[base]), 32'b0001);
    drain();

    // Single source: FIFO 2 only.
    fq[2].push_back(10'h101);
    fq[2].push_back(10'h102);
    base = re_log.size();
    for (int k = 0; k < 4; k++) step();
    check("ss_re0", 32'(re_log[base]), 32'b0100);
    check("ss_re1", 32'(re_log[base+1]), 32'b0100);
    check("ss_re2", 32'(re_log[base+2]), 32'b0000);
    check("ss_vo0", 32'(vo_log[base]), 32'd0);
    check("ss_vo1", 32'(vo_log[base+1]), 32'd1);
    check("ss_pk1", 32'(pkto_log[base+1]), 32'h101);
    check("ss_vo2", 32'(vo_log[base+2]), 32'd1);
    check("ss_pk2", 32'(pkto_log[base+2]), 32'h102);
    check("ss_vo3", 32'(vo_log[base+3]), 32'd0);

    // Round-robin from a fresh pointer: 3 packets per FIFO, incl. all-zero.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NIN; i++)
      for (int j = 0; j < 3; j++) fq[i].push_back(10'(i * 12'h100 + j * 12'h011));
    base = re_log.size();
    for (int k = 0; k < 13; k++) step();
    for (int k = 0; k < 12; k++) begin
      check($sformatf("rr_re%0d", k), 32'(re_log[base+k]), 32'(1) << (k % 4));
      check($sformatf("rr_vo%0d", k), 32'(vo_log[base+k+1]), 32'd1);
    end
    check("rr_zero_pkt", 32'(pkto_log[base+1]), 32'h000);
    check("rr_last_pkt", 32'(pkto_log[base+12]), 32'h322);
    drain();

    // Backpressure: hold 0x2AB for 5 cycles, then release.
    fq[1].push_back(10'h2AB);
    fq[1].push_back(10'h055);
    ri = 1'b0;
    base = re_log.size();
    step();
    for (int k = 0; k < 5; k++) step();
    ri = 1'b1;
    step();
    step();
    check("bp_re_first", 32'(re_log[base]), 32'b0010);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("bp_re%0d", k), 32'(re_log[base+k]), 32'h0);
      check($sformatf("bp_vo%0d", k), 32'(vo_log[base+k]), 32'd1);
      check($sformatf("bp_pk%0d", k), 32'(pkto_log[base+k]), 32'h2AB);
    end
    check("bp_re_rel", 32'(re_log[base+6]), 32'b0010);
    check("bp_pk_next", 32'(pkto_log[base+7]), 32'h055);
    drain();

    // Pointer skip/wrap: bring rr to 3, then only FIFOs 1 and 3 request.
    fq[2].push_back(10'h0AA);
    base = re_log.size();
    step();
    step();
    fq[1].push_back(10'h111);
    fq[3].push_back(10'h333);
    step();
    step();
    step();
    for (int i = 0; i < NIN; i++) fq[i].push_back(10'(12'h200 + i));
    step();
    check("pw_re_a", 32'(re_log[base]), 32'b0100);
    check("pw_pk_a", 32'(pkto_log[base+1]), 32'h0AA);
    check("pw_re_3", 32'(re_log[base+2]), 32'b1000);
    check("pw_re_1", 32'(re_log[base+3]), 32'b0010);
    check("pw_pk_3", 32'(pkto_log[base+3]), 32'h333);
    check("pw_pk_1", 32'(pkto_log[base+4]), 32'h111);
    check("pw_rr2", 32'(re_log[base+5]), 32'b0100);
    drain();

`ifdef SW_PKTCNT_EN
    // Counter wrap: 70000 transfers from reset leave 70000 mod 65536.
    begin
      int guard = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      while (xfers < 70000 && guard < 71000) begin
        if (fq[0].size() < 2) fq[0].push_back(10'(guard));
        step();
        guard++;
      end
      check("cnt_bound", 32'(xfers), 32'd70000);
      check("cnt_wrap", 32'(pktcnt), 32'd4464);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("cnt_rst", 32'(pktcnt), 32'd0);
      for (int i = 0; i < NIN; i++) fq[i].delete();
      drain();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_sched.md
# rr_sched

Round-robin read scheduler sitting directly downstream of the switch's per-input `fifo` instances. It watches the `empty` flags of four input FIFOs, pops at most one packet per cycle in round-robin order, and presents it on a registered valid/ready output toward the output link. It owns every `re` strobe going into those FIFOs, so it never reads an empty FIFO.

## Interface
- `NIN`, 4: number of input FIFOs served; fixed by `sw.vh`, not overridable per instance.
- `PKTW`, from `sw.vh` (9): packet MSB index, so packets are `PKTW+1` = 10 bits wide.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `empty`  in  NIN  per-FIFO empty flag; bit i = FIFO i.
- `pkti`  in  NIN*(PKTW+1)  concatenated FIFO head packets; slice i = FIFO i `pkto`, valid combinationally while `empty[i]` is low.
- `re`  out  NIN  one-hot or zero pop strobe to FIFO i.
- `pkto`  out  PKTW+1  output packet register.
- `vo`  out  1  `pkto` holds a valid packet.
- `ri`  in  1  downstream ready; transfer happens on a cycle where `vo && ri`.
- `pktcnt`  out  16  forwarded-packet count; present only with `SW_PKTCNT_EN`.

## Operation
- State: output register `pkto`/`vo`; round-robin pointer `rr` (2 bits), which is the highest-priority input for the next grant.
- Slot free: `free = !vo || ri`.
- Grant: when `free`, pick the first i with `empty[i]` low, scanning `rr, rr+1, …` modulo NIN. Assert `re[i]` combinationally in that cycle. No candidate or not free means `re` = 0.
- On grant: `pkto <= pkti[i]`, `vo <= 1`, `rr <= i+1` (mod NIN, natural 2-bit wrap).
- No grant and `vo && ri`: `vo <= 0`. `pkto` keeps its old value, and its contents are don't-care.
- `vo && !ri`: `pkto`, `vo`, and `rr` hold, and `re` = 0 (backpressure).
- `re` is never asserted for an input whose `empty` bit is high. At most one `re` bit is high per cycle.
- Packets are forwarded unmodified, including all-zero packets. There is no filtering on header bits [9:8].
- Flag levels use `ASSERT`/`NEGATE` from `sw.vh`.

## Timing
- Reset, next edge: `vo` = 0, `pkto` = 0, `rr` = 0, `pktcnt` = 0. `re` = 0 during any cycle with `rst` high.
- Latency: FIFO non-empty at cycle t with slot free gives `re` high in t and `vo` high in t+1.
- Throughput: one packet per cycle when `ri` is held high and any FIFO is non-empty. Back-to-back grants are allowed in the same cycle as an output transfer.
- Fairness: with all four non-empty and `ri` = 1, the grant order is 0,1,2,3,0,… Any input waits at most NIN−1 grants.
- Simultaneous transfer and grant: the new packet replaces the old one, and `vo` stays high.
- Reset mid-operation: the packet in `pkto` is lost. FIFOs are reset by the same `rst`, so no pop is lost or duplicated.
- FIFO that becomes empty after its last pop: it is not considered until its `empty` bit drops again.

## Configuration
- `SW_PKTCNT_EN` defined:
  - Adds the `pktcnt` port.
  - Increments on every `vo && ri` transfer.
  - 16 bits, wraps from 0xFFFF to 0.
  - Cleared by `rst`.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- `sw.vh` gains `NIN` and `NINB` (pointer MSB, 1), alongside the existing `PKTW`, `ASSERT`, and `NEGATE`.
- One combinational sub-module, `rr_arb`:
  - Inputs: request vector (`~empty & {NIN{free}}`) and `rr`.
  - Outputs: one-hot grant and grant index.
- `rr_sched` holds the registers, the pointer update, and the optional counter.

## Test plan
- Reset: hold `rst` 2 cycles with all FIFOs non-empty. `re` = 0 throughout; after release `vo` = 0, `pkto` = 0, `rr` = 0.
- Single source: only FIFO 2 non-empty with packets 0x101, 0x102, `ri` = 1.
  - `re` = 4'b0100 for two consecutive cycles.
  - `pkto` = 0x101 then 0x102, with `vo` high for 2 cycles.
- Round-robin: all four FIFOs hold 3 packets, `ri` = 1. Grant order is 0,1,2,3,0,1,2,3,0,1,2,3 over 12 consecutive cycles with no bubbles.
- Backpressure: `vo` = 1 with `pkto` = 0x2AB, `ri` = 0 for 5 cycles. `re` = 0 and `pkto` stays 0x2AB; on `ri` = 1 the next packet loads the following cycle.
- Pointer skip/wrap: `rr` = 3, only FIFOs 1 and 3 non-empty. Grant 3, then 1; `rr` ends at 2.
- With `SW_PKTCNT_EN`: 70000 transfers give `pktcnt` = 4464 (wrap). Asserting `rst` clears it to 0.
